// File: rtl/pc_ctrl_if.sv
// Fetch-stage bus between the pipeline control logic and the program-counter unit.
// The master drives stall/redirect requests; the slave (pc_ctrl) returns the fetch address and status.
interface pc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [ADDR_W-1:0] pc_o;
  logic              ce_o;
  logic              misalign_o;
  logic              br_pending_o;

  modport master (
    output stall_i, branch_i, branch_target_i, flush_i, flush_pc_i,
    input  pc_o, ce_o, misalign_o, br_pending_o
  );

  modport slave (
    input  stall_i, branch_i, branch_target_i, flush_i, flush_pc_i,
    output pc_o, ce_o, misalign_o, br_pending_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter unit for the fetch stage: sequential fetch, stall, branch and flush
// redirects, plus a one-entry buffer so a branch raised during a stall is not lost.
module pc_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC       = 4,
  parameter int                ALIGN     = 2
) (
  input logic       clk,
  input logic       rst,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] buf_target_q, buf_target_d;
  logic              buf_valid_q, buf_valid_d;
  logic              ce_q, ce_d;
  logic              mis_q, mis_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      pc_q         <= RESET_VEC;
      buf_target_q <= '0;
      buf_valid_q  <= 1'b0;
      ce_q         <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_target_q <= buf_target_d;
      buf_valid_q  <= buf_valid_d;
      ce_q         <= ce_d;
      mis_q        <= mis_d;
    end
  end

  // Buffered targets are stored already aligned; their misalign pulse fires at store time.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_target_d = buf_target_q;
    buf_valid_d  = buf_valid_q;
    ce_d         = ce_q;
    mis_d        = 1'b0;
    case (state_q)
      OFF: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end
      default: begin
        ce_d = 1'b1;
        if (bus.flush_i) begin
          pc_d        = bus.flush_pc_i & ALIGN_MASK;
          mis_d       = |(bus.flush_pc_i & ~ALIGN_MASK);
          buf_valid_d = 1'b0;
          state_d     = RUN;
        end else if (bus.stall_i) begin
          state_d = HOLD;
          if (bus.branch_i) begin
            buf_target_d = bus.branch_target_i & ALIGN_MASK;
            buf_valid_d  = 1'b1;
            mis_d        = |(bus.branch_target_i & ~ALIGN_MASK);
          end
        end else if (bus.branch_i) begin
          pc_d        = bus.branch_target_i & ALIGN_MASK;
          mis_d       = |(bus.branch_target_i & ~ALIGN_MASK);
          buf_valid_d = 1'b0;
          state_d     = RUN;
        end else if (buf_valid_q) begin
          pc_d        = buf_target_q;
          buf_valid_d = 1'b0;
          state_d     = RUN;
        end else begin
          pc_d    = pc_q + STEP;
          state_d = RUN;
        end
      end
    endcase
  end

  assign bus.pc_o         = pc_q;
  assign bus.ce_o         = ce_q;
  assign bus.misalign_o   = mis_q;
  assign bus.br_pending_o = buf_valid_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Table-driven bench for pc_ctrl: each record is one cycle of stimulus plus the outputs
// expected after that cycle's rising edge, queued on drive and checked once the edge has passed.
module tb_pc_ctrl;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] tgt;
    logic        flush;
    logic [31:0] fpc;
    logic [31:0] pc;
    logic        ce;
    logic        mis;
    logic        pend;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   step;
  vec_t sb[$];
  vec_t vecs[$];

  pc_ctrl_if #(.ADDR_W(32)) bus ();

  pc_ctrl #(
    .ADDR_W(32), .RESET_VEC(32'h0000_0000), .INC(4), .ALIGN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic s, input logic b, input logic [31:0] t,
                             input logic f, input logic [31:0] fp, input logic [31:0] pc,
                             input logic ce, input logic mis, input logic pend);
    vec_t x;
    x.rst = r; x.stall = s; x.branch = b; x.tgt = t; x.flush = f; x.fpc = fp;
    x.pc = pc; x.ce = ce; x.mis = mis; x.pend = pend;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", step);
    end else begin
      e = sb.pop_front();
      cmp("pc_o", bus.pc_o, e.pc);
      cmp("ce_o", {31'b0, bus.ce_o}, {31'b0, e.ce});
      cmp("misalign_o", {31'b0, bus.misalign_o}, {31'b0, e.mis});
      cmp("br_pending_o", {31'b0, bus.br_pending_o}, {31'b0, e.pend});
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst                 = t.rst;
    bus.stall_i         = t.stall;
    bus.branch_i        = t.branch;
    bus.branch_target_i = t.tgt;
    bus.flush_i         = t.flush;
    bus.flush_pc_i      = t.fpc;
    sb.push_back(t);
    @(posedge clk);
    #1;
    checkOutput();
    step++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    step   = 0;
    rst    = 1'b1;
    bus.stall_i = 1'b0; bus.branch_i = 1'b0; bus.branch_target_i = '0;
    bus.flush_i = 1'b0; bus.flush_pc_i = '0;

    //                 rst s  b  target        f  flush_pc      pc            ce mis pend
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    // A branch seen while still OFF must be ignored.
    vecs.push_back(v(0, 0, 1, 32'h900,      0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       1, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h400,      0, 32'h0,        32'h400,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h404,      1, 0, 0));
    vecs.push_back(v(0, 1, 1, 32'h200,      0, 32'h0,        32'h404,      1, 0, 1));
    vecs.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,        32'h404,      1, 0, 1));
    vecs.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,        32'h404,      1, 0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 0));
    vecs.push_back(v(0, 1, 1, 32'h300,      0, 32'h0,        32'h204,      1, 0, 1));
    vecs.push_back(v(0, 1, 1, 32'h340,      0, 32'h0,        32'h204,      1, 0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h340,      1, 0, 0));
    // A live branch on stall release outranks and discards the buffered one.
    vecs.push_back(v(0, 1, 1, 32'h500,      0, 32'h0,        32'h340,      1, 0, 1));
    vecs.push_back(v(0, 0, 1, 32'h600,      0, 32'h0,        32'h600,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h604,      1, 0, 0));
    vecs.push_back(v(0, 1, 1, 32'h700,      0, 32'h0,        32'h604,      1, 0, 1));
    vecs.push_back(v(0, 1, 0, 32'h0,        1, 32'h180,      32'h180,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h184,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h188,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 32'h1F2,      32'h1F0,      1, 1, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h1F4,      1, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h900,      1, 32'h80,       32'h80,       1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1, 0, 0));
    vecs.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,        32'h84,       1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h88,       1, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Misaligned direct branch: one-cycle misalign pulse with the aligned target.
    applyStimulus(v(0, 0, 1, 32'h403, 0, 32'h0, 32'h400, 1, 1, 0));
    applyStimulus(v(0, 0, 0, 32'h0,   0, 32'h0, 32'h404, 1, 0, 0));
    // Misaligned branch captured during a stall pulses at store time, not at consume time.
    applyStimulus(v(0, 1, 1, 32'h2A1, 0, 32'h0, 32'h404, 1, 1, 1));
    applyStimulus(v(0, 1, 0, 32'h0,   0, 32'h0, 32'h404, 1, 0, 1));
    applyStimulus(v(0, 0, 0, 32'h0,   0, 32'h0, 32'h2A0, 1, 0, 0));
    // Reset mid-stall with a full buffer drops everything and restarts at OFF.
    applyStimulus(v(0, 1, 1, 32'h800, 0, 32'h0, 32'h2A0, 1, 0, 1));
    applyStimulus(v(1, 1, 0, 32'h0,   0, 32'h0, 32'h0,   0, 0, 0));
    applyStimulus(v(0, 0, 0, 32'h0,   0, 32'h0, 32'h0,   1, 0, 0));
    applyStimulus(v(0, 0, 0, 32'h0,   0, 32'h0, 32'h4,   1, 0, 0));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
